// File: rtl/sid_pkg.sv
// Shared types and constants for the SID envelope generator.
package sid_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned WAVE_W = 12;
    localparam int unsigned ENV_W  = 8;
    localparam int unsigned RATE_W = 15;
    localparam int unsigned EXP_W  = 5;

    // Register offsets from the voice base address.
    localparam int unsigned REG_CTRL = 4;
    localparam int unsigned REG_AD   = 5;
    localparam int unsigned REG_SR   = 6;

    typedef enum logic [1:0] {
        ATTACK        = 2'd0,
        DECAY_SUSTAIN = 2'd1,
        RELEASE       = 2'd2
    } env_state_t;

    // Rate counter compare values, indexed by the 4-bit rate nibble.
    localparam logic [RATE_W-1:0] RATE_PERIOD [16] = '{
        15'd9,    15'd32,   15'd63,   15'd95,
        15'd149,  15'd220,  15'd267,  15'd313,
        15'd392,  15'd977,  15'd1954, 15'd3126,
        15'd3907, 15'd11720, 15'd19532, 15'd31251
    };

    // Lower bound of each exponential band (envelope value).
    localparam logic [ENV_W-1:0] EXP_TH_1  = 8'd94;
    localparam logic [ENV_W-1:0] EXP_TH_2  = 8'd55;
    localparam logic [ENV_W-1:0] EXP_TH_4  = 8'd27;
    localparam logic [ENV_W-1:0] EXP_TH_8  = 8'd15;
    localparam logic [ENV_W-1:0] EXP_TH_16 = 8'd7;

    // Rate steps per envelope decrement for a given envelope level.
    function automatic logic [EXP_W-1:0] exp_period(input logic [ENV_W-1:0] level);
        if (level >= EXP_TH_1) begin
            return EXP_W'(1);
        end else if (level >= EXP_TH_2) begin
            return EXP_W'(2);
        end else if (level >= EXP_TH_4) begin
            return EXP_W'(4);
        end else if (level >= EXP_TH_8) begin
            return EXP_W'(8);
        end else if (level >= EXP_TH_16) begin
            return EXP_W'(16);
        end else begin
            return EXP_W'(30);
        end
    endfunction

endpackage

// File: rtl/sid_env_rate.sv
// Rate prescaler: 15-bit counter compared against the selected period.
module sid_env_rate
    import sid_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic [3:0] rate,
    output logic       step_c
);

    logic [RATE_W-1:0] rate_cnt;
    logic [RATE_W-1:0] period;
    logic              at_period;

    // Period lookup and step pulse for the current tick.
    always_comb begin
        period    = RATE_PERIOD[rate];
        at_period = (rate_cnt == period);
        step_c    = tick & at_period;
    end

    // Counter keeps its phase across rate changes; wraps if the period drops below it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rate_cnt <= '0;
        end else if (tick) begin
            if (at_period) begin
                rate_cnt <= '0;
            end else begin
                rate_cnt <= rate_cnt + RATE_W'(1);
            end
        end
    end

endmodule

// File: rtl/sid_envelope.sv
// Per-voice ADSR envelope generator and VCA.
module sid_envelope
    import sid_pkg::*;
#(
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              CLKen,
    input  logic              WR,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] DATA,
    input  logic [WAVE_W-1:0] VOICE_IN,
    output logic [ENV_W-1:0]  ENV_OUT,
    output logic [WAVE_W-1:0] OUTPUT
);

    localparam logic [ADDR_W-1:0] ADDR_CTRL = ADDR_W'(BASE_ADDR + REG_CTRL);
    localparam logic [ADDR_W-1:0] ADDR_AD   = ADDR_W'(BASE_ADDR + REG_AD);
    localparam logic [ADDR_W-1:0] ADDR_SR   = ADDR_W'(BASE_ADDR + REG_SR);
    localparam logic [ENV_W-1:0]  ENV_MAX   = '1;
    localparam int unsigned       PROD_W    = WAVE_W + ENV_W;

    logic [3:0]        attack_rate;
    logic [3:0]        decay_rate;
    logic [3:0]        sustain_lvl;
    logic [3:0]        release_rate;
    logic              gate;
    logic              gate_lag;
    env_state_t        state;
    env_state_t        state_eff;
    logic [ENV_W-1:0]  env;
    logic [EXP_W-1:0]  exp_cnt;
    logic [EXP_W-1:0]  exp_inc;
    logic [EXP_W-1:0]  exp_per;
    logic              exp_hit;
    logic              gate_rise;
    logic              gate_fall;
    logic              dec_ok;
    logic [3:0]        rate_sel;
    logic              rate_step;
    logic [PROD_W-1:0] vca_prod;

    assign ENV_OUT = env;

    // Gate edge detection, effective state for this tick and derived controls.
    always_comb begin
        gate_rise = gate & ~gate_lag;
        gate_fall = ~gate & gate_lag;

        state_eff = state;
        if (CLKen && gate_rise) begin
            state_eff = ATTACK;
        end else if (CLKen && gate_fall) begin
            state_eff = RELEASE;
        end

        rate_sel = release_rate;
        case (state_eff)
            ATTACK:        rate_sel = attack_rate;
            DECAY_SUSTAIN: rate_sel = decay_rate;
            default:       rate_sel = release_rate;
        endcase

        exp_per = exp_period(env);
        exp_inc = exp_cnt + EXP_W'(1);
        exp_hit = (exp_inc >= exp_per);

        // Sustain level nibble maps to nibble*17 ({n,n}) on the 8-bit scale.
        if (state_eff == RELEASE) begin
            dec_ok = (env != '0);
        end else begin
            dec_ok = (env > {sustain_lvl, sustain_lvl});
        end

        vca_prod = PROD_W'(VOICE_IN) * PROD_W'(env);
    end

    sid_env_rate u_rate (
        .clk    (CLK),
        .rst_n  (RSTn),
        .tick   (CLKen),
        .rate   (rate_sel),
        .step_c (rate_step)
    );

    // Register decode, envelope state machine, envelope counter and VCA output.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            attack_rate  <= '0;
            decay_rate   <= '0;
            sustain_lvl  <= '0;
            release_rate <= '0;
            gate         <= 1'b0;
            gate_lag     <= 1'b0;
            state        <= RELEASE;
            env          <= '0;
            exp_cnt      <= '0;
            OUTPUT       <= '0;
        end else begin
            if (WR) begin
                if (ADDR == ADDR_CTRL) begin
                    gate <= DATA[0];
                end else if (ADDR == ADDR_AD) begin
                    attack_rate <= DATA[7:4];
                    decay_rate  <= DATA[3:0];
                end else if (ADDR == ADDR_SR) begin
                    sustain_lvl  <= DATA[7:4];
                    release_rate <= DATA[3:0];
                end
            end

            OUTPUT <= WAVE_W'(vca_prod >> ENV_W);

            if (CLKen) begin
                gate_lag <= gate;
                state    <= state_eff;
                if (gate_rise) begin
                    exp_cnt <= '0;
                end
                if (rate_step) begin
                    if (state_eff == ATTACK) begin
                        if (env != ENV_MAX) begin
                            env <= env + ENV_W'(1);
                        end
                        if (env >= ENV_MAX - ENV_W'(1)) begin
                            state <= DECAY_SUSTAIN;
                        end
                    end else if (exp_hit) begin
                        exp_cnt <= '0;
                        if (dec_ok) begin
                            env <= env - ENV_W'(1);
                        end
                    end else begin
                        exp_cnt <= exp_inc;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sid_envelope.sv
// Self-checking bench for sid_envelope with a tick-level behavioural model.
`timescale 1ns/1ps
module tb_sid_envelope;

    localparam int BASE = 8;
    localparam int PH_ATT = 0;
    localparam int PH_DS  = 1;
    localparam int PH_REL = 2;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        CLKen = 1'b0;
    logic        WR = 1'b0;
    logic [4:0]  ADDR = '0;
    logic [7:0]  DATA = '0;
    logic [11:0] VOICE_IN = '0;
    logic [7:0]  ENV_OUT;
    logic [11:0] OUTPUT;

    sid_envelope #(.BASE_ADDR(BASE)) dut (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .CLKen    (CLKen),
        .WR       (WR),
        .ADDR     (ADDR),
        .DATA     (DATA),
        .VOICE_IN (VOICE_IN),
        .ENV_OUT  (ENV_OUT),
        .OUTPUT   (OUTPUT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    int periods [16] = '{9, 32, 63, 95, 149, 220, 267, 313,
                         392, 977, 1954, 3126, 3907, 11720, 19532, 31251};

    // Behavioural envelope state
    int m_att, m_dec, m_sus, m_rel, m_gate, m_lag, m_rc, m_exp, m_env, m_ph, m_out;
    logic [11:0] v_cur = '0;

    function automatic int exp_per_of(input int e);
        if (e >= 94) return 1;
        if (e >= 55) return 2;
        if (e >= 27) return 4;
        if (e >= 15) return 8;
        if (e >= 7)  return 16;
        return 30;
    endfunction

    // Advance the model by one CLK edge using the inputs present at that edge.
    task automatic model_edge();
        int  per;
        int  nib;
        bit  rise;
        bit  fall;
        bit  step;
        bit  allow;
        if (RSTn !== 1'b1) begin
            m_att = 0; m_dec = 0; m_sus = 0; m_rel = 0;
            m_gate = 0; m_lag = 0; m_rc = 0; m_exp = 0; m_env = 0;
            m_ph = PH_REL; m_out = 0;
            return;
        end
        m_out = (int'(VOICE_IN) * m_env) / 256;
        if (CLKen) begin
            rise = (m_gate == 1) && (m_lag == 0);
            fall = (m_gate == 0) && (m_lag == 1);
            if (rise) begin
                m_ph = PH_ATT;
                m_exp = 0;
            end else if (fall) begin
                m_ph = PH_REL;
            end
            m_lag = m_gate;
            nib = (m_ph == PH_ATT) ? m_att : (m_ph == PH_DS) ? m_dec : m_rel;
            per = periods[nib];
            step = (m_rc == per);
            m_rc = step ? 0 : (m_rc + 1) % 32768;
            if (step) begin
                if (m_ph == PH_ATT) begin
                    if (m_env < 255) m_env = m_env + 1;
                    if (m_env == 255) m_ph = PH_DS;
                end else begin
                    m_exp = m_exp + 1;
                    if (m_exp >= exp_per_of(m_env)) begin
                        m_exp = 0;
                        allow = (m_ph == PH_DS) ? (m_env > m_sus * 17) : (m_env > 0);
                        if (allow) m_env = m_env - 1;
                    end
                end
            end
        end
        if (WR) begin
            if (int'(ADDR) == BASE + 4) begin
                m_gate = int'(DATA[0]);
            end else if (int'(ADDR) == BASE + 5) begin
                m_att = int'(DATA[7:4]);
                m_dec = int'(DATA[3:0]);
            end else if (int'(ADDR) == BASE + 6) begin
                m_sus = int'(DATA[7:4]);
                m_rel = int'(DATA[3:0]);
            end
        end
    endtask

    task automatic drive(input logic rst, input logic en, input logic wr,
                         input logic [4:0] a, input logic [7:0] d);
        @(negedge CLK);
        RSTn = rst; CLKen = en; WR = wr; ADDR = a; DATA = d; VOICE_IN = v_cur;
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0, 5'd0, 8'd0);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 5'd0, 8'd0);
    endtask

    task automatic write_reg(input int off, input logic [7:0] d);
        drive(1'b1, 1'b0, 1'b1, 5'(BASE + off), d);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 8'd0);
    endtask

    task automatic test_reset();
        v_cur = 12'hFFF;
        drive(1'b0, 1'b1, 1'b1, 5'(BASE + 4), 8'h01);
        drive(1'b0, 1'b1, 1'b1, 5'(BASE + 4), 8'h01);
        checks++;
        if (ENV_OUT !== 8'h00) begin errors++; $display("FAIL reset_env: got %0h expected 0", ENV_OUT); end
        checks++;
        if (OUTPUT !== 12'h000) begin errors++; $display("FAIL reset_out: got %0h expected 0", OUTPUT); end
        tick(30);
        checks++;
        if (ENV_OUT !== 8'h00) begin errors++; $display("FAIL reset_idle_env: got %0h expected 0", ENV_OUT); end
        checks++;
        if (OUTPUT !== 12'h000) begin errors++; $display("FAIL reset_idle_out: got %0h expected 0", OUTPUT); end
    endtask

    task automatic test_attack();
        do_reset();
        v_cur = 12'h000;
        write_reg(5, 8'h00);
        write_reg(4, 8'h01);
        for (int k = 1; k <= 2550; k++) begin
            tick(1);
            checks++;
            if (ENV_OUT !== 8'(k / 10)) begin
                errors++;
                $display("FAIL attack_ramp tick=%0d: got %0d expected %0d", k, ENV_OUT, k / 10);
            end
        end
        tick(9);
        checks++;
        if (ENV_OUT !== 8'hFF) begin errors++; $display("FAIL attack_peak: got %0h expected ff", ENV_OUT); end
        tick(1);
        checks++;
        if (ENV_OUT !== 8'hFE) begin errors++; $display("FAIL attack_to_decay: got %0h expected fe", ENV_OUT); end
    endtask

    task automatic test_decay_sustain();
        int last;
        int t_last;
        int changes;
        bit first;
        do_reset();
        write_reg(5, 8'h00);
        write_reg(6, 8'hA0);
        write_reg(4, 8'h01);
        tick(2550);
        checks++;
        if (ENV_OUT !== 8'hFF) begin errors++; $display("FAIL ds_peak: got %0h expected ff", ENV_OUT); end
        for (int n = 1; n <= 85; n++) begin
            tick(9);
            checks++;
            if (ENV_OUT !== 8'(256 - n)) begin
                errors++; $display("FAIL ds_before_step n=%0d: got %0d expected %0d", n, ENV_OUT, 256 - n);
            end
            tick(1);
            checks++;
            if (ENV_OUT !== 8'(255 - n)) begin
                errors++; $display("FAIL ds_step n=%0d: got %0d expected %0d", n, ENV_OUT, 255 - n);
            end
        end
        for (int i = 0; i < 10; i++) begin
            tick(100);
            checks++;
            if (ENV_OUT !== 8'hAA) begin errors++; $display("FAIL ds_hold: got %0h expected aa", ENV_OUT); end
        end
        write_reg(6, 8'hF0);
        for (int i = 0; i < 10; i++) begin
            tick(100);
            checks++;
            if (ENV_OUT !== 8'hAA) begin errors++; $display("FAIL ds_sustain_raised: got %0h expected aa", ENV_OUT); end
        end
        write_reg(4, 8'h00);
        last = int'(ENV_OUT);
        t_last = 0;
        changes = 0;
        first = 1'b1;
        for (int t = 1; t <= 7500 && ENV_OUT != 8'h00; t++) begin
            tick(1);
            if (int'(ENV_OUT) != last) begin
                checks++;
                if (int'(ENV_OUT) != last - 1) begin
                    errors++; $display("FAIL rel_single_step: got %0d expected %0d", ENV_OUT, last - 1);
                end
                if (!first) begin
                    checks++;
                    if (t - t_last != 10 * exp_per_of(last)) begin
                        errors++;
                        $display("FAIL rel_interval env=%0d: got %0d ticks expected %0d", last, t - t_last, 10 * exp_per_of(last));
                    end
                end
                first = 1'b0;
                t_last = t;
                last = int'(ENV_OUT);
                changes++;
            end
        end
        checks++;
        if (changes != 170) begin errors++; $display("FAIL rel_count: got %0d decrements expected 170", changes); end
        tick(500);
        checks++;
        if (ENV_OUT !== 8'h00) begin errors++; $display("FAIL rel_floor: got %0h expected 0", ENV_OUT); end
    endtask

    task automatic test_gate_toggle();
        do_reset();
        write_reg(5, 8'h00);
        write_reg(4, 8'h01);
        tick(640);
        checks++;
        if (ENV_OUT !== 8'h40) begin errors++; $display("FAIL toggle_start: got %0h expected 40", ENV_OUT); end
        tick(3);
        write_reg(4, 8'h00);
        tick(1);
        write_reg(4, 8'h01);
        tick(1);
        tick(4);
        checks++;
        if (ENV_OUT !== 8'h40) begin errors++; $display("FAIL toggle_pre_step: got %0h expected 40", ENV_OUT); end
        tick(1);
        checks++;
        if (ENV_OUT !== 8'h41) begin errors++; $display("FAIL toggle_phase: got %0h expected 41", ENV_OUT); end
        tick(10);
        checks++;
        if (ENV_OUT !== 8'h42) begin errors++; $display("FAIL toggle_resume: got %0h expected 42", ENV_OUT); end
        write_reg(4, 8'h00);
        tick(40);
        checks++;
        if (ENV_OUT >= 8'h42 || ENV_OUT !== 8'(m_env)) begin
            errors++; $display("FAIL toggle_release: got %0h expected %0h", ENV_OUT, m_env);
        end
    endtask

    task automatic test_vca();
        logic [11:0] v;
        do_reset();
        v_cur = 12'h800;
        write_reg(5, 8'h00);
        write_reg(4, 8'h01);
        tick(1280);
        checks++;
        if (OUTPUT !== 12'h3F8) begin errors++; $display("FAIL vca_latency: got %0h expected 3f8", OUTPUT); end
        hold(1);
        checks++;
        if (OUTPUT !== 12'h400) begin errors++; $display("FAIL vca_half: got %0h expected 400", OUTPUT); end
        v_cur = 12'hFFF;
        hold(1);
        checks++;
        if (OUTPUT !== 12'h7FF) begin errors++; $display("FAIL vca_new_input: got %0h expected 7ff", OUTPUT); end
        v_cur = 12'h800;
        tick(1270);
        hold(1);
        checks++;
        if (OUTPUT !== 12'h7F8) begin errors++; $display("FAIL vca_full: got %0h expected 7f8", OUTPUT); end
        for (int i = 0; i < 20; i++) begin
            v = 12'($urandom_range(0, 4095));
            v_cur = v;
            hold(1);
            checks++;
            if (OUTPUT !== 12'((int'(v) * 255) / 256)) begin
                errors++; $display("FAIL vca_rand v=%0h: got %0h expected %0h", v, OUTPUT, (int'(v) * 255) / 256);
            end
        end
    endtask

    task automatic test_reset_mid_decay();
        int n;
        do_reset();
        v_cur = 12'hFFF;
        write_reg(5, 8'h10);
        write_reg(4, 8'h01);
        n = 0;
        while (ENV_OUT != 8'hFF && n < 9000) begin tick(1); n++; end
        n = 0;
        while (ENV_OUT != 8'h90 && n < 3000) begin tick(1); n++; end
        checks++;
        if (ENV_OUT !== 8'h90) begin errors++; $display("FAIL mid_reach: got %0h expected 90", ENV_OUT); end
        drive(1'b0, 1'b1, 1'b0, 5'd0, 8'd0);
        checks++;
        if (ENV_OUT !== 8'h00) begin errors++; $display("FAIL mid_reset_env: got %0h expected 0", ENV_OUT); end
        checks++;
        if (OUTPUT !== 12'h000) begin errors++; $display("FAIL mid_reset_out: got %0h expected 0", OUTPUT); end
        write_reg(4, 8'h01);
        tick(9);
        checks++;
        if (ENV_OUT !== 8'h00) begin errors++; $display("FAIL mid_rate0_wait: got %0h expected 0", ENV_OUT); end
        tick(1);
        checks++;
        if (ENV_OUT !== 8'h01) begin errors++; $display("FAIL mid_rate0_step: got %0h expected 1", ENV_OUT); end
    endtask

    task automatic test_random();
        logic       en;
        logic       wr;
        logic       rst;
        logic [4:0] a;
        logic [7:0] d;
        int         sel;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            v_cur = 12'($urandom_range(0, 4095));
            rst = ($urandom_range(0, 1999) != 0);
            en  = ($urandom_range(0, 3) != 0);
            wr  = ($urandom_range(0, 15) == 0);
            sel = $urandom_range(0, 3);
            case (sel)
                0: begin a = 5'(BASE + 4); d = 8'($urandom_range(0, 255)); end
                1: begin a = 5'(BASE + 5); d = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 1))}; end
                2: begin a = 5'(BASE + 6); d = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 1))}; end
                default: begin a = 5'($urandom_range(0, 31)); d = 8'($urandom_range(0, 255)); end
            endcase
            if (sel == 3 && (int'(a) == BASE + 5 || int'(a) == BASE + 6)) d = 8'h11;
            drive(rst, en, wr, a, d);
            checks++;
            if (ENV_OUT !== 8'(m_env)) begin
                errors++; $display("FAIL rand_env cyc=%0d: got %0h expected %0h", i, ENV_OUT, m_env);
            end
            checks++;
            if (OUTPUT !== 12'(m_out)) begin
                errors++; $display("FAIL rand_out cyc=%0d: got %0h expected %0h", i, OUTPUT, m_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_attack();
        test_decay_sustain();
        test_gate_toggle();
        test_vca();
        test_reset_mid_decay();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: run did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
